// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants, register map and FSM state type for the SPI register-write link
package spi_pkg;

   localparam int         FRAME_BITS = 16;
   localparam logic       RW_WRITE   = 1'b1;

   // Peripheral register map
   localparam logic [6:0] EN_OUT_7_0  = 7'h00;
   localparam logic [6:0] EN_OUT_15_8 = 7'h01;
   localparam logic [6:0] EN_PWM_7_0  = 7'h02;
   localparam logic [6:0] EN_PWM_15_8 = 7'h03;
   localparam logic [6:0] PWM_DUTY    = 7'h04;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HI,
      ST_LO,
      ST_HOLD,
      ST_GAP
   } spi_ctrl_state_t;

   // Largest of four timing parameters; sizes the shared phase timer
   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - two-flop synchronizer for the peripheral-to-controller data line
module spi_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops give the asynchronous input time to settle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 initiator for the 16-bit register link; optional read path under SPI_CTRL_READ_EN
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4,
   parameter int CS_IDLE  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       nCS,
   output logic       SCLK,
   output logic       COPI
`ifdef SPI_CTRL_READ_EN
   ,
   input  logic       CIPO
`endif
);

   // One timer serves every phase, so it is sized for the longest one
   localparam int TMAX = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE);
   localparam int TW   = $clog2(TMAX);

   localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
   localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
   localparam logic [TW-1:0] IDLE_LAST  = TW'(CS_IDLE - 1);

   if (CLK_DIV < 3) begin : g_bad_clk_div
      $error("spi_controller: CLK_DIV must be at least 3");
   end
   if (CS_SETUP < 3) begin : g_bad_cs_setup
      $error("spi_controller: CS_SETUP must be at least 3");
   end
   if (CS_HOLD < 3) begin : g_bad_cs_hold
      $error("spi_controller: CS_HOLD must be at least 3");
   end
   if (CS_IDLE < 1) begin : g_bad_cs_idle
      $error("spi_controller: CS_IDLE must be at least 1");
   end

   spi_ctrl_state_t         state, state_n;
   logic [TW-1:0]           tmr, tmr_n;
   logic [4:0]              bit_cnt, bit_n;
   // Bits still to be sent after the one currently on COPI, MSB next
   logic [FRAME_BITS-2:0]   shreg, shreg_n;
   logic [FRAME_BITS-1:0]   frame;
   logic                    ncs_q, ncs_n;
   logic                    sclk_q, sclk_n;
   logic                    copi_q, copi_n;
   logic                    rsp_valid_q, rsp_valid_n;

`ifdef SPI_CTRL_READ_EN
   logic       cipo_s;
   logic       rd_frame, rd_frame_n;
   logic [7:0] rd_sh, rd_sh_n;
   logic [7:0] rdata_q, rdata_n;

   spi_sync2 u_cipo_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (CIPO),
      .q     (cipo_s)
   );
`else
   logic unused_rw;
   assign unused_rw = req_rw;
`endif

   assign req_ready = (state == ST_IDLE);
   assign nCS       = ncs_q;
   assign SCLK      = sclk_q;
   assign COPI      = copi_q;
   assign rsp_valid = rsp_valid_q;
`ifdef SPI_CTRL_READ_EN
   assign rsp_rdata = rdata_q;
`else
   assign rsp_rdata = 8'h00;
`endif

   // Next-state decode; pin values are computed here and registered below
   always_comb begin
      state_n     = state;
      tmr_n       = tmr;
      bit_n       = bit_cnt;
      shreg_n     = shreg;
      frame       = '0;
      ncs_n       = ncs_q;
      sclk_n      = sclk_q;
      copi_n      = copi_q;
      rsp_valid_n = 1'b0;
`ifdef SPI_CTRL_READ_EN
      rd_frame_n  = rd_frame;
      rd_sh_n     = rd_sh;
      rdata_n     = rdata_q;
`endif
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
`ifdef SPI_CTRL_READ_EN
               frame      = {req_rw, req_addr, req_rw ? req_wdata : 8'h00};
               rd_frame_n = ~req_rw;
`else
               frame      = {RW_WRITE, req_addr, req_wdata};
`endif
               state_n = ST_SETUP;
               tmr_n   = '0;
               bit_n   = '0;
               ncs_n   = 1'b0;
               copi_n  = frame[FRAME_BITS-1];
               shreg_n = frame[FRAME_BITS-2:0];
            end
         end
         ST_SETUP: begin
            if (tmr == SETUP_LAST) begin
               state_n = ST_HI;
               tmr_n   = '0;
               sclk_n  = 1'b1;
               bit_n   = bit_cnt + 5'd1;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         ST_HI: begin
            if (tmr == DIV_LAST) begin
`ifdef SPI_CTRL_READ_EN
               if (rd_frame && bit_cnt >= 5'd9) begin
                  rd_sh_n = {rd_sh[6:0], cipo_s};
               end
`endif
               tmr_n  = '0;
               sclk_n = 1'b0;
               if (bit_cnt == 5'd16) begin
                  state_n = ST_HOLD;
               end else begin
                  state_n = ST_LO;
                  copi_n  = shreg[FRAME_BITS-2];
                  shreg_n = {shreg[FRAME_BITS-3:0], 1'b0};
               end
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         ST_LO: begin
            if (tmr == DIV_LAST) begin
               state_n = ST_HI;
               tmr_n   = '0;
               sclk_n  = 1'b1;
               bit_n   = bit_cnt + 5'd1;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         ST_HOLD: begin
            if (tmr == HOLD_LAST) begin
               state_n     = ST_GAP;
               tmr_n       = '0;
               ncs_n       = 1'b1;
               copi_n      = 1'b0;
               rsp_valid_n = 1'b1;
`ifdef SPI_CTRL_READ_EN
               if (rd_frame) begin
                  rdata_n = rd_sh;
               end
`endif
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         ST_GAP: begin
            if (tmr == IDLE_LAST) begin
               state_n = ST_IDLE;
               tmr_n   = '0;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            tmr_n   = '0;
         end
      endcase
   end

   // FSM, timers and SPI pin flops; reset drops the frame in flight immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         tmr         <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         ncs_q       <= 1'b1;
         sclk_q      <= 1'b0;
         copi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state       <= state_n;
         tmr         <= tmr_n;
         bit_cnt     <= bit_n;
         shreg       <= shreg_n;
         ncs_q       <= ncs_n;
         sclk_q      <= sclk_n;
         copi_q      <= copi_n;
         rsp_valid_q <= rsp_valid_n;
      end
   end

`ifdef SPI_CTRL_READ_EN
   // Read-path capture: frame direction, incoming byte and the held read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_frame <= 1'b0;
         rd_sh    <= 8'h00;
         rdata_q  <= 8'h00;
      end else begin
         rd_frame <= rd_frame_n;
         rd_sh    <= rd_sh_n;
         rdata_q  <= rdata_n;
      end
   end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - self-checking bench for spi_controller with a waveform model and a peripheral model
`timescale 1ns/1ps
module tb_spi_controller;
   import spi_pkg::*;

   localparam int CLK_DIV    = 4;
   localparam int CS_SETUP   = 4;
   localparam int CS_HOLD    = 4;
   localparam int CS_IDLE    = 4;
   localparam int SCLK_SPAN  = 31 * CLK_DIV;
   localparam int LOW_LEN    = CS_SETUP + SCLK_SPAN + CS_HOLD;
   localparam int FRAME_SPAN = LOW_LEN + 1 + CS_IDLE;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_rw = 1'b1;
   logic [6:0] req_addr = 7'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       req_ready, rsp_valid, nCS, SCLK, COPI;
   logic [7:0] rsp_rdata;
`ifdef SPI_CTRL_READ_EN
   logic       CIPO = 1'b0;
`endif

   always #5 clk = ~clk;

   spi_controller #(
      .CLK_DIV  (CLK_DIV),
      .CS_SETUP (CS_SETUP),
      .CS_HOLD  (CS_HOLD),
      .CS_IDLE  (CS_IDLE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .nCS       (nCS),
      .SCLK      (SCLK),
      .COPI      (COPI)
`ifdef SPI_CTRL_READ_EN
      ,
      .CIPO      (CIPO)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Waveform model state: accept cycle and frame of the transfer in flight
   bit          m_busy  = 1'b0;
   int          m_t0    = 0;
   logic [15:0] m_frame = 16'h0000;
   logic [7:0]  m_rdata = 8'h00;
   logic [7:0]  cipo_byte = 8'h5A;

   // Peripheral model and line measurements
   logic [15:0] p_shift = 16'h0000;
   int          p_bits = 0;
   logic [7:0]  p_regs [128];
   logic [15:0] p_last_frame = 16'h0000;
   int          low_run = 0, high_run = 0, last_low = 0, last_gap = 0;
   int          rsp_cnt = 0, fall_cnt = 0;
   logic        prev_sclk = 1'b0, prev_ncs = 1'b1;

   initial begin
      for (int i = 0; i < 128; i++) p_regs[i] = 8'h00;
   end

   // Every cycle: compare DUT pins against the frame timing rules, then run the peripheral model
   always @(negedge clk) begin
      int   k;
      int   half;
      logic e_ncs, e_sclk, e_copi, e_rsp, idle;
      cyc++;
      e_ncs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0; e_rsp = 1'b0;
      if (!rst_n) begin
         m_busy  = 1'b0;
         m_rdata = 8'h00;
      end else if (m_busy) begin
         k = cyc - m_t0;
         if (k >= 1 && k <= CS_SETUP) begin
            e_ncs = 1'b0; e_copi = m_frame[15];
         end else if (k > CS_SETUP && k <= CS_SETUP + SCLK_SPAN) begin
            half   = (k - CS_SETUP - 1) / CLK_DIV;
            e_ncs  = 1'b0;
            e_sclk = (half % 2 == 0);
            e_copi = m_frame[15 - (half + 1) / 2];
         end else if (k > CS_SETUP + SCLK_SPAN && k <= LOW_LEN) begin
            e_ncs = 1'b0; e_copi = m_frame[0];
         end else if (k == LOW_LEN + 1) begin
            e_rsp = 1'b1;
            if (!m_frame[15]) m_rdata = cipo_byte;
         end
         if (k >= FRAME_SPAN) m_busy = 1'b0;
      end
      idle = !m_busy;
      check("nCS", nCS, e_ncs);
      check("SCLK", SCLK, e_sclk);
      check("COPI", COPI, e_copi);
      check("rsp_valid", rsp_valid, e_rsp);
      check("req_ready", req_ready, idle);
      check("rsp_rdata", rsp_rdata, m_rdata);
      if (rst_n && idle && req_valid) begin
         m_busy = 1'b1;
         m_t0   = cyc;
`ifdef SPI_CTRL_READ_EN
         m_frame = {req_rw, req_addr, req_rw ? req_wdata : 8'h00};
`else
         m_frame = {1'b1, req_addr, req_wdata};
`endif
      end

      if (rsp_valid) rsp_cnt++;
      if (prev_ncs && !nCS) begin
         last_gap = high_run;
         low_run  = 0;
         p_bits   = 0;
         fall_cnt = 0;
      end
      if (!prev_ncs && nCS) begin
         last_low     = low_run;
         high_run     = 0;
         p_last_frame = p_shift;
         if (p_bits == 16 && p_shift[15]) p_regs[p_shift[14:8]] = p_shift[7:0];
      end
      if (!nCS && SCLK && !prev_sclk) begin
         p_shift = {p_shift[14:0], COPI};
         p_bits++;
      end
      if (!nCS && !SCLK && prev_sclk) begin
         fall_cnt++;
`ifdef SPI_CTRL_READ_EN
         if (fall_cnt >= 8 && fall_cnt <= 15) CIPO = cipo_byte[15 - fall_cnt];
`endif
      end
      if (!nCS) low_run++;
      else high_run++;
      prev_sclk = SCLK;
      prev_ncs  = nCS;
   end

   task automatic wait_accept();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 400);
      check("accept_timeout", n < 400, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d);
      req_rw    = rw;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      wait_accept();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      int n = 0;
      while (rsp_cnt < target && n < 400) begin
         @(posedge clk);
         n++;
      end
      check("rsp_timeout", rsp_cnt >= target, 1'b1);
      repeat (CS_IDLE + 2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_nCS", nCS, 1'b1);
      check("reset_ready", req_ready, 1'b1);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single write to PWM_DUTY
      send(RW_WRITE, PWM_DUTY, 8'hA5);
      wait_rsp(1);
      check("w1_frame", p_last_frame, 16'h84A5);
      check("w1_low_len", last_low, 132);
      check("w1_rsp_count", rsp_cnt, 1);
      check("w1_pwm_duty", p_regs[PWM_DUTY], 8'hA5);

      // Back-to-back writes with req_valid held high
      req_rw = RW_WRITE; req_addr = EN_OUT_7_0; req_wdata = 8'h11; req_valid = 1'b1;
      wait_accept();
      req_addr = EN_OUT_15_8; req_wdata = 8'h22;
      wait_accept();
      req_valid = 1'b0;
      wait_rsp(3);
      check("b2b_gap", last_gap, CS_IDLE + 1);
      check("b2b_reg0", p_regs[EN_OUT_7_0], 8'h11);
      check("b2b_reg1", p_regs[EN_OUT_15_8], 8'h22);
      check("b2b_rsp_count", rsp_cnt, 3);

      // Request inputs wiggled during a frame must not disturb it
      send(RW_WRITE, EN_OUT_7_0, 8'h96);
      repeat (20) @(posedge clk);
      #1;
      req_addr = EN_PWM_15_8; req_wdata = 8'hFF; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = EN_PWM_7_0;
      wait_rsp(4);
      check("mid_frame", p_last_frame, 16'h8096);
      check("mid_reg0", p_regs[EN_OUT_7_0], 8'h96);
      check("mid_reg3", p_regs[EN_PWM_15_8], 8'h00);
      check("mid_rsp_count", rsp_cnt, 4);

      // Reset asserted during the 7th SCLK high phase
      send(RW_WRITE, EN_OUT_15_8, 8'h77);
      repeat (54) @(posedge clk);
      #1;
      check("pre_reset_sclk", SCLK, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_nCS", nCS, 1'b1);
      check("rst_SCLK", SCLK, 1'b0);
      check("rst_COPI", COPI, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_count", rsp_cnt, 4);
      check("rst_reg1_kept", p_regs[EN_OUT_15_8], 8'h22);
      send(RW_WRITE, EN_PWM_7_0, 8'h3C);
      wait_rsp(5);
      check("post_rst_frame", p_last_frame, 16'h823C);
      check("post_rst_reg2", p_regs[EN_PWM_7_0], 8'h3C);
      check("post_rst_low_len", last_low, 132);

`ifdef SPI_CTRL_READ_EN
      // Read of EN_PWM_15_8 with the peripheral returning 0x5A
      send(1'b0, EN_PWM_15_8, 8'hC3);
      wait_rsp(6);
      check("rd_frame", p_last_frame, 16'h0300);
      check("rd_rdata", rsp_rdata, 8'h5A);
      send(RW_WRITE, EN_OUT_7_0, 8'h12);
      wait_rsp(7);
      check("rd_rdata_held", rsp_rdata, 8'h5A);
      check("rd_then_write", p_regs[EN_OUT_7_0], 8'h12);
`else
      // Read request is forced to a write when the read path is absent
      send(1'b0, EN_OUT_15_8, 8'hFF);
      wait_rsp(6);
      check("noread_frame", p_last_frame, 16'h81FF);
      check("noread_rdata", rsp_rdata, 8'h00);
      check("noread_reg1", p_regs[EN_OUT_15_8], 8'hFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
